// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding, width constants and result conventions.
package alu_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned REM_W = WIDTH + 1;

    localparam logic [WIDTH-1:0] INT_MIN  = 32'h8000_0000;
    localparam logic [WIDTH-1:0] ALL_ONES = 32'hFFFF_FFFF;

    // A divide by zero returns all ones as the quotient and the dividend as the remainder.
    localparam logic [WIDTH-1:0] DIV_ZERO_QUOTIENT = ALL_ONES;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + WIDTH'(1)) : v;
    endfunction

endpackage

// File: rtl/alu_divider_seq_if.sv
// Start/done handshake and operand/result bus between the ALU controller and the divider.
interface alu_divider_seq_if;
    import alu_pkg::*;

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;
    logic             overflow;

    modport master (
        output start, is_signed, X, Y,
        input  busy, done, quotient, remainder, div_zero, overflow
    );

    modport slave (
        input  start, is_signed, X, Y,
        output busy, done, quotient, remainder, div_zero, overflow
    );

endinterface

// File: rtl/alu_divider_seq_div_step.sv
// One restoring-division step: shift in the next dividend bit and trial-subtract the divisor.
module div_step
    import alu_pkg::*;
(
    input  logic [REM_W-1:0] r_i,
    input  logic             x_msb_i,
    input  logic [WIDTH-1:0] ymag_i,
    output logic [REM_W-1:0] r_o,
    output logic             q_bit_o
);

    logic [REM_W:0] shifted;
    logic [REM_W:0] diff;

    // One spare bit on top keeps the borrow unambiguous; R < Ymag keeps the result within REM_W.
    always_comb begin
        shifted = {r_i, x_msb_i};
        diff    = shifted - (REM_W + 1)'(ymag_i);
        q_bit_o = ~diff[REM_W];
        r_o     = q_bit_o ? REM_W'(diff) : REM_W'(shifted);
    end

endmodule

// File: rtl/alu_divider_seq.sv
// Sequential restoring divider, one quotient bit per cycle, signed/unsigned with sign fix-up.
module alu_divider_seq
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    alu_divider_seq_if.slave   bus
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] xmag_q, xmag_d;
    logic [WIDTH-1:0] ymag_q, ymag_d;
    logic [WIDTH-1:0] quo_acc_q, quo_acc_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic             special_q, special_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;
    logic             overflow_q, overflow_d;

    logic             x_neg, y_neg, is_zero, is_ovf;
    logic [REM_W-1:0] step_r;
    logic             step_q;

    div_step u_div_step (
        .r_i     (rem_q),
        .x_msb_i (xmag_q[WIDTH-1]),
        .ymag_i  (ymag_q),
        .r_o     (step_r),
        .q_bit_o (step_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        xmag_d      = xmag_q;
        ymag_d      = ymag_q;
        quo_acc_d   = quo_acc_q;
        sign_q_d    = sign_q_q;
        sign_r_d    = sign_r_q;
        special_d   = special_q;
        zero_d      = zero_q;
        busy_d      = busy_q;
        done_d      = done_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;

        x_neg   = bus.is_signed & bus.X[WIDTH-1];
        y_neg   = bus.is_signed & bus.Y[WIDTH-1];
        is_zero = (bus.Y == '0);
        is_ovf  = bus.is_signed && (bus.X == INT_MIN) && (bus.Y == ALL_ONES);

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // On divide by zero no steps run, so the raw dividend is parked for the remainder.
                    xmag_d     = is_zero ? bus.X : neg_if(bus.X, x_neg);
                    ymag_d     = neg_if(bus.Y, y_neg);
                    sign_q_d   = x_neg ^ y_neg;
                    sign_r_d   = x_neg;
                    cnt_d      = '0;
                    rem_d      = '0;
                    quo_acc_d  = '0;
                    div_zero_d = 1'b0;
                    overflow_d = 1'b0;
                    special_d  = is_zero | is_ovf;
                    zero_d     = is_zero;
                    busy_d     = 1'b1;
                    state_d    = (is_zero | is_ovf) ? FIX : CALC;
                end
            end
            CALC: begin
                xmag_d    = xmag_q << 1;
                rem_d     = step_r;
                quo_acc_d = {quo_acc_q[WIDTH-2:0], step_q};
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (special_q && zero_q) begin
                    quotient_d  = DIV_ZERO_QUOTIENT;
                    remainder_d = xmag_q;
                    div_zero_d  = 1'b1;
                end else if (special_q) begin
                    quotient_d  = INT_MIN;
                    remainder_d = '0;
                    overflow_d  = 1'b1;
                end else begin
                    quotient_d  = neg_if(quo_acc_q, sign_q_q);
                    remainder_d = neg_if(rem_q[WIDTH-1:0], sign_r_q);
                end
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            xmag_q      <= '0;
            ymag_q      <= '0;
            quo_acc_q   <= '0;
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
            special_q   <= 1'b0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            xmag_q      <= xmag_d;
            ymag_q      <= ymag_d;
            quo_acc_q   <= quo_acc_d;
            sign_q_q    <= sign_q_d;
            sign_r_q    <= sign_r_d;
            special_q   <= special_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.overflow  = overflow_q;

endmodule
